// File: rtl/pipelined_adder_pkg.sv
// Shared constants for the pipelined execute-stage adder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipelined_adder_pkg;

  // Operation select values carried on the sub input.
  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

  // Default geometry: 32-bit datapath split into four 8-bit slices.
  localparam int DEF_WIDTH  = 32;
  localparam int DEF_STAGES = 4;

endpackage

// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle between the EX stage and the pipelined adder.
// Latency: n/a (wiring only).
// Backpressure: in_rdy/out_rdy valid-ready pairs on the request and result sides.
interface pipelined_adder_if
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             in_vld;
  logic             in_rdy;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_vld;
  logic             out_rdy;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             zero;

  // Requester: offers operands, consumes results.
  modport master (
    output in_vld, a, b, sub, out_rdy,
    input  in_rdy, out_vld, result, carry_out, overflow, zero
  );

  // Adder: accepts operands, produces results.
  modport slave (
    input  in_vld, a, b, sub, out_rdy,
    output in_rdy, out_vld, result, carry_out, overflow, zero
  );

endinterface

// File: rtl/pipelined_adder_slice.sv
// Combinational SW-bit ripple slice with carry out and carry into its MSB.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the owning pipeline stage decides when to register it.
module adder_slice #(
  parameter int SW = 8
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          cin,
  output logic [SW-1:0] sum,
  output logic          cout,
  output logic          c_msb
);

  if (SW == 1) begin : g_one
    // A one-bit slice sees cin directly at its MSB.
    assign c_msb = cin;
    assign sum   = a ^ b ^ cin;
  end else begin : g_multi
    logic [SW-1:0] low;

    // Add everything below the MSB; the top bit of low is the carry into the MSB.
    assign low   = {1'b0, a[SW-2:0]} + {1'b0, b[SW-2:0]} + {{(SW-1){1'b0}}, cin};
    assign c_msb = low[SW-1];
    assign sum   = {a[SW-1] ^ b[SW-1] ^ c_msb, low[SW-2:0]};
  end

  // Carry out of the MSB is the majority of its three inputs.
  assign cout = (a[SW-1] & b[SW-1]) | (c_msb & (a[SW-1] ^ b[SW-1]));

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit add/subtract split into STAGES carry-linked slices, one slice per cycle.
// Latency: STAGES cycles from acceptance to out_vld; one operation per cycle throughput.
// Backpressure: global stall; every stage holds while out_vld && !out_rdy, in_rdy follows.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  pipelined_adder_if.slave   bus
);

  localparam int SW = WIDTH / STAGES;

  logic             advance;
  logic             out_vld;
  logic [WIDTH-1:0] bx;

  // The whole pipe moves together unless the output slot is full and not taken.
  assign advance    = !out_vld || bus.out_rdy;
  assign bus.in_rdy = advance;

  // Subtract is A + ~B + 1; the +1 enters as the slice-0 carry-in.
  assign bx = (bus.sub == ALU_ADD) ? bus.b : ~bus.b;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    // Operand bits still to be added when an entry reaches this stage's slice.
    localparam int REM = WIDTH - k * SW;

    logic [REM-1:0]        src_a;
    logic [REM-1:0]        src_b;
    logic                  cin;
    logic                  p_vld;
    logic [SW-1:0]         sum;
    logic                  cout;
    logic                  cmsb;
    logic [(k+1)*SW-1:0]   res_d;
    logic [(k+1)*SW-1:0]   res_q;
    logic                  vld_q;
    logic                  c_q;

    if (k == 0) begin : g_head
      assign src_a = bus.a;
      assign src_b = bx;
      assign cin   = bus.sub;
      assign p_vld = bus.in_vld;
      assign res_d = sum;
    end else begin : g_body
      assign src_a = g_st[k-1].g_ops.a_q;
      assign src_b = g_st[k-1].g_ops.b_q;
      assign cin   = g_st[k-1].c_q;
      assign p_vld = g_st[k-1].vld_q;
      assign res_d = {sum, g_st[k-1].res_q};
    end

    adder_slice #(
      .SW (SW)
    ) u_slice (
      .a     (src_a[SW-1:0]),
      .b     (src_b[SW-1:0]),
      .cin   (cin),
      .sum   (sum),
      .cout  (cout),
      .c_msb (cmsb)
    );

    if (k < STAGES - 1) begin : g_ops
      logic [REM-SW-1:0] a_q;
      logic [REM-SW-1:0] b_q;

      // Skewed operand registers: hand the unprocessed upper slices to the next stage.
      always_ff @(posedge clk) begin
        if (reset) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance) begin
          a_q <= src_a[REM-1:SW];
          b_q <= src_b[REM-1:SW];
        end
      end

      // Intermediate stage: valid, partial result and slice carry shift on every advance.
      always_ff @(posedge clk) begin
        if (reset) begin
          vld_q <= 1'b0;
          res_q <= '0;
          c_q   <= 1'b0;
        end else begin
          if (flush) begin
            vld_q <= 1'b0;
          end else if (advance) begin
            vld_q <= p_vld;
          end
          if (advance) begin
            res_q <= res_d;
            c_q   <= cout;
          end
        end
      end
    end else begin : g_tail
      logic ovf_q;
      logic zero_q;

      // Output stage: data and flags load only when a live entry arrives, so they hold under stall.
      always_ff @(posedge clk) begin
        if (reset) begin
          vld_q  <= 1'b0;
          res_q  <= '0;
          c_q    <= 1'b0;
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else begin
          if (flush) begin
            vld_q <= 1'b0;
          end else if (advance) begin
            vld_q <= p_vld;
          end
          if (advance && p_vld && !flush) begin
            res_q  <= res_d;
            c_q    <= cout;
            ovf_q  <= cmsb ^ cout;
            zero_q <= (res_d == '0);
          end
        end
      end
    end
  end

  assign out_vld       = g_st[STAGES-1].vld_q;
  assign bus.out_vld   = out_vld;
  assign bus.result    = g_st[STAGES-1].res_q;
  assign bus.carry_out = g_st[STAGES-1].c_q;
  assign bus.overflow  = g_st[STAGES-1].g_tail.ovf_q;
  assign bus.zero      = g_st[STAGES-1].g_tail.zero_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: 4-stage and 1-stage instances, scoreboard on every output.
// Latency: checks STAGES-cycle latency on the first transaction after reset and flush.
// Backpressure: exercises fixed and random out_rdy stalls against in_rdy and output stability.
module tb_pipelined_adder;
  import pipelined_adder_pkg::*;

  typedef struct {
    logic [31:0] r;
    logic        c;
    logic        v;
    logic        z;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    exp_t        e;
  } vec_t;

  logic clk;
  logic reset;
  logic flush;

  int total;
  int bad;

  exp_t q4[$];
  exp_t q1[$];
  exp_t m4;
  exp_t m1;
  vec_t tbl[6];

  pipelined_adder_if #(.WIDTH(32)) bus4 ();
  pipelined_adder_if #(.WIDTH(32)) bus1 ();

  pipelined_adder #(.WIDTH(32), .STAGES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus4)
  );

  pipelined_adder #(.WIDTH(32), .STAGES(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t        m;
    logic [31:0] bxx;
    logic [32:0] full;
    bxx  = s ? ~b : b;
    full = {1'b0, a} + {1'b0, bxx} + {32'd0, s};
    m.r  = full[31:0];
    m.c  = full[32];
    m.v  = (a[31] == bxx[31]) && (full[31] != a[31]);
    m.z  = (full[31:0] == 32'd0);
    return m;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, want);
    end
  endtask

  // Scoreboard: every consumed result is compared with the oldest expected entry.
  always @(negedge clk) begin
    if (!reset && bus4.out_vld && bus4.out_rdy) begin
      if (q4.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious4: got result %h expected no output", bus4.result);
      end else begin
        m4 = q4.pop_front();
        chk("result4", bus4.result, m4.r);
        chk("carry4", {31'd0, bus4.carry_out}, {31'd0, m4.c});
        chk("ovf4", {31'd0, bus4.overflow}, {31'd0, m4.v});
        chk("zero4", {31'd0, bus4.zero}, {31'd0, m4.z});
      end
    end
    if (!reset && bus1.out_vld && bus1.out_rdy) begin
      if (q1.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious1: got result %h expected no output", bus1.result);
      end else begin
        m1 = q1.pop_front();
        chk("result1", bus1.result, m1.r);
        chk("carry1", {31'd0, bus1.carry_out}, {31'd0, m1.c});
        chk("ovf1", {31'd0, bus1.overflow}, {31'd0, m1.v});
        chk("zero1", {31'd0, bus1.zero}, {31'd0, m1.z});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one op on the 4-stage bus; expectation is queued when acceptance is certain.
  task automatic send4(input logic [31:0] a, input logic [31:0] b, input logic s, input exp_t e);
    bus4.in_vld = 1'b1;
    bus4.a      = a;
    bus4.b      = b;
    bus4.sub    = s;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus4.in_rdy) begin
        q4.push_back(e);
        @(posedge clk);
        #1;
        bus4.in_vld = 1'b0;
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL send4: in_rdy got 0 for 50 cycles expected 1");
    bus4.in_vld = 1'b0;
  endtask

  // Single op into an idle 4-stage pipe, measuring cycles from accepting edge to out_vld.
  task automatic lat4(input logic [31:0] a, input logic [31:0] b, input logic s, input exp_t e,
                      input string nm);
    int lat;
    lat         = 0;
    bus4.in_vld = 1'b1;
    bus4.a      = a;
    bus4.b      = b;
    bus4.sub    = s;
    @(negedge clk);
    chk({nm, "_inrdy"}, {31'd0, bus4.in_rdy}, 32'd1);
    q4.push_back(e);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      lat++;
      #1;
      bus4.in_vld = 1'b0;
      @(negedge clk);
      if (bus4.out_vld) break;
    end
    chk({nm, "_latency"}, lat, 32'd4);
    step();
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (q4.size() == 0 && q1.size() == 0) return;
      step();
    end
    total++;
    bad++;
    $display("FAIL drain: pending got %0d expected 0", q4.size() + q1.size());
  endtask

  initial begin
    int lat1;
    total = 0;
    bad   = 0;

    tbl[0] = '{a: 32'h0000_0005, b: 32'h0000_0003, s: ALU_ADD, e: '{r: 32'h0000_0008, c: 1'b0, v: 1'b0, z: 1'b0}};
    tbl[1] = '{a: 32'h00FF_FFFF, b: 32'h0000_0001, s: ALU_ADD, e: '{r: 32'h0100_0000, c: 1'b0, v: 1'b0, z: 1'b0}};
    tbl[2] = '{a: 32'hFFFF_FFFF, b: 32'h0000_0001, s: ALU_ADD, e: '{r: 32'h0000_0000, c: 1'b1, v: 1'b0, z: 1'b1}};
    tbl[3] = '{a: 32'h7FFF_FFFF, b: 32'h0000_0001, s: ALU_ADD, e: '{r: 32'h8000_0000, c: 1'b0, v: 1'b1, z: 1'b0}};
    tbl[4] = '{a: 32'h0000_0005, b: 32'h0000_0007, s: ALU_SUB, e: '{r: 32'hFFFF_FFFE, c: 1'b0, v: 1'b0, z: 1'b0}};
    tbl[5] = '{a: 32'h8000_0000, b: 32'h0000_0001, s: ALU_SUB, e: '{r: 32'h7FFF_FFFF, c: 1'b1, v: 1'b1, z: 1'b0}};

    reset        = 1'b1;
    flush        = 1'b0;
    bus4.in_vld  = 1'b0;
    bus4.a       = '0;
    bus4.b       = '0;
    bus4.sub     = 1'b0;
    bus4.out_rdy = 1'b1;
    bus1.in_vld  = 1'b0;
    bus1.a       = '0;
    bus1.b       = '0;
    bus1.sub     = 1'b0;
    bus1.out_rdy = 1'b1;
    step();
    step();
    reset = 1'b0;

    // Reset state.
    @(negedge clk);
    chk("rst_outvld", {31'd0, bus4.out_vld}, 32'd0);
    chk("rst_inrdy", {31'd0, bus4.in_rdy}, 32'd1);
    chk("rst_result", bus4.result, 32'd0);
    chk("rst_flags", {29'd0, bus4.carry_out, bus4.overflow, bus4.zero}, 32'd0);
    chk("rst1_result", bus1.result, 32'd0);
    step();

    // First op after reset: 5+3 with exact latency.
    lat4(tbl[0].a, tbl[0].b, tbl[0].s, tbl[0].e, "first");
    drain();

    // Table vectors back to back.
    for (int i = 1; i < 6; i++) send4(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].e);
    drain();

    // Eight ops A=i,B=100 with a 3-cycle output stall in the middle.
    fork
      begin
        for (int i = 0; i < 8; i++) send4(i, 32'd100, ALU_ADD, model(i, 32'd100, ALU_ADD));
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        bus4.out_rdy = 1'b0;
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          chk("stall_inrdy", {31'd0, bus4.in_rdy}, 32'd0);
          chk("stall_outvld", {31'd0, bus4.out_vld}, 32'd1);
          chk("stall_hold", bus4.result, q4[0].r);
          step();
        end
        bus4.out_rdy = 1'b1;
      end
    join
    drain();

    // Flush with three in flight and a fourth offered in the flush cycle.
    for (int i = 0; i < 3; i++) send4(32'd10 + i, 32'd1, ALU_ADD, model(32'd10 + i, 32'd1, ALU_ADD));
    bus4.in_vld = 1'b1;
    bus4.a      = 32'd7;
    bus4.b      = 32'd7;
    bus4.sub    = ALU_ADD;
    flush       = 1'b1;
    step();
    flush       = 1'b0;
    bus4.in_vld = 1'b0;
    q4.delete();
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      chk("flush_outvld", {31'd0, bus4.out_vld}, 32'd0);
      step();
    end
    lat4(32'd2, 32'd2, ALU_ADD, '{r: 32'd4, c: 1'b0, v: 1'b0, z: 1'b0}, "postflush");
    drain();

    // Reset with two ops in flight.
    send4(32'd20, 32'd5, ALU_ADD, model(32'd20, 32'd5, ALU_ADD));
    send4(32'd30, 32'd5, ALU_SUB, model(32'd30, 32'd5, ALU_SUB));
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_outvld", {31'd0, bus4.out_vld}, 32'd0);
    chk("midrst_result", bus4.result, 32'd0);
    chk("midrst_flags", {29'd0, bus4.carry_out, bus4.overflow, bus4.zero}, 32'd0);
    chk("midrst_inrdy", {31'd0, bus4.in_rdy}, 32'd1);
    q4.delete();
    step();
    reset = 1'b0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      chk("postrst_outvld", {31'd0, bus4.out_vld}, 32'd0);
      step();
    end

    // Random operands under random output back-pressure.
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          logic [31:0] ra;
          logic [31:0] rb;
          logic        rs;
          ra = $urandom;
          rb = $urandom;
          rs = 1'($urandom_range(0, 1));
          send4(ra, rb, rs, model(ra, rb, rs));
        end
      end
      begin
        for (int j = 0; j < 60; j++) begin
          bus4.out_rdy = ($urandom_range(0, 3) != 0);
          step();
        end
        bus4.out_rdy = 1'b1;
      end
    join
    bus4.out_rdy = 1'b1;
    drain();

    // Single-stage build: latency 1, 5+3.
    lat1        = 0;
    bus1.in_vld = 1'b1;
    bus1.a      = 32'd5;
    bus1.b      = 32'd3;
    bus1.sub    = ALU_ADD;
    @(negedge clk);
    chk("s1_inrdy", {31'd0, bus1.in_rdy}, 32'd1);
    q1.push_back('{r: 32'd8, c: 1'b0, v: 1'b0, z: 1'b0});
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      lat1++;
      #1;
      bus1.in_vld = 1'b0;
      @(negedge clk);
      if (bus1.out_vld) break;
    end
    chk("s1_latency", lat1, 32'd1);
    step();
    drain();

    chk("q4_empty", q4.size(), 32'd0);
    chk("q1_empty", q1.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
